// File: rtl/sne_evt_stream_pkg.sv
// Shared types for the DP_GROUP event stream path: spike payload, packer FSM state, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sne_evt_stream_pkg;

  // One spike as it travels on the event streams: source tag plus amplitude.
  typedef struct packed {
    logic [3:0] src;
    logic [7:0] amp;
  } spike_t;

  // Group packer FSM: collect spikes into lanes, then hold the beat until granted.
  typedef enum logic [0:0] {PK_FILL, PK_ISSUE} packer_state_t;

  // Idle cycles a partial group may sit before it is pushed out.
  localparam int unsigned PK_TIMEOUT_DEFAULT = 64;

  // Lanes per group beat.
  localparam int unsigned PK_DP_GROUP_DEFAULT = 16;

endpackage

// File: rtl/evt_packer_idle_timer.sv
// Saturating idle counter for a partially filled group; pulses when the group has waited long enough.
// Latency: pulse is combinational from the registered count (same cycle as the TIMEOUT-th idle cycle).
// Backpressure: none; clr_i restarts the count, run_i gates counting. TIMEOUT==0 ties the pulse low.
module evt_packer_idle_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic engine_clk_i,
  input  logic engine_rst_i,
  input  logic clr_i,
  input  logic run_i,
  output logic timeout_o
);

  if (TIMEOUT == 0) begin : g_no_timeout
    // Timeout disabled: no counter, the pulse never fires.
    logic unused_in;
    assign unused_in = engine_clk_i ^ engine_rst_i ^ clr_i ^ run_i;
    assign timeout_o = 1'b0;
  end else begin : g_timeout
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Count idle cycles while a group is held; saturate at TIMEOUT-1, restart on clear.
    always_ff @(posedge engine_clk_i) begin
      if (engine_rst_i) begin
        cnt <= '0;
      end else if (clr_i) begin
        cnt <= '0;
      end else if (run_i && (cnt != LAST)) begin
        cnt <= cnt + CW'(1);
      end
    end

    // A clear in the same cycle (fresh accept or grant) suppresses the pulse.
    assign timeout_o = run_i & ~clr_i & (cnt == LAST);
  end

endmodule

// File: rtl/evt_group_packer.sv
// Packs a serial spike stream (spike + lane per beat) into one DP_GROUP-wide group beat for the event mapper.
// Latency: group visible the cycle after its trigger (collision/full/flush/timeout); completes on first grant cycle.
// Backpressure: evt_in_ready_o drops on an occupied lane or while a group is held; beat holds until spike_grant_i.
// Optional: define SNE_EVT_PACKER_STATS_EN for group/spike counters on stat_groups_o / stat_evts_o.
module evt_group_packer
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned DP_GROUP = PK_DP_GROUP_DEFAULT,
  parameter int unsigned TIMEOUT  = PK_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned LANE_W  = $clog2(DP_GROUP)
) (
  input  logic                        engine_clk_i,
  input  logic                        engine_rst_i,
  input  logic                        evt_in_valid_i,
  output logic                        evt_in_ready_o,
  input  spike_t                      evt_in_spike_i,
  input  logic [LANE_W-1:0]           evt_in_lane_i,
  input  logic                        flush_i,
  output logic [DP_GROUP-1:0]         evt_valid_o,
  output spike_t [DP_GROUP-1:0]       evt_spike_o,
  input  logic                        spike_grant_i,
  output logic                        busy_o,
  output logic [CNT_W-1:0]            stat_groups_o,
  output logic [CNT_W-1:0]            stat_evts_o
);

  packer_state_t         state;
  logic [DP_GROUP-1:0]   occ;
  logic [DP_GROUP-1:0]   occ_nxt;
  logic [DP_GROUP-1:0]   lane_oh;
  logic [DP_GROUP-1:0]   issue_mask;
  spike_t [DP_GROUP-1:0] payload;
  logic                  flush_pend;

  logic in_fill;
  logic lane_ok;
  logic lane_busy;
  logic accept;
  logic collision;
  logic trig;
  logic go_issue;
  logic grant_fire;
  logic timeout;

  // Decode the target lane and derive accept / collision / issue decisions for this cycle.
  always_comb begin
    in_fill   = (state == PK_FILL);
    // Out-of-range lanes only exist for non power-of-2 groups; such spikes are swallowed.
    lane_ok   = (32'(evt_in_lane_i) < DP_GROUP);
    lane_oh   = '0;
    if (lane_ok) begin
      lane_oh[evt_in_lane_i] = 1'b1;
    end
    lane_busy      = |(occ & lane_oh);
    evt_in_ready_o = in_fill & ~lane_busy;
    accept         = evt_in_valid_i & evt_in_ready_o;
    collision      = in_fill & evt_in_valid_i & lane_busy;
    occ_nxt        = occ | (accept ? lane_oh : '0);
    trig           = collision | (&occ_nxt) | flush_i | flush_pend | timeout;
    // Never issue an empty beat: flush/timeout with nothing held is a no-op.
    go_issue       = in_fill & (|occ_nxt) & trig;
    grant_fire     = ~in_fill & spike_grant_i;
  end

  evt_packer_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .engine_clk_i (engine_clk_i),
    .engine_rst_i (engine_rst_i),
    .clr_i        (accept | grant_fire),
    .run_i        (|occ),
    .timeout_o    (timeout)
  );

  // Packer FSM: fill lanes, then hold the group until the mapper grants it.
  always_ff @(posedge engine_clk_i) begin
    if (engine_rst_i) begin
      state      <= PK_FILL;
      occ        <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        PK_FILL: begin
          occ <= occ_nxt;
          if (go_issue) begin
            state      <= PK_ISSUE;
            // The pending flush is consumed by the group now being issued.
            flush_pend <= 1'b0;
          end
        end
        PK_ISSUE: begin
          // A flush seen while holding a beat targets the next group.
          if (flush_i) begin
            flush_pend <= 1'b1;
          end
          if (spike_grant_i) begin
            occ   <= '0;
            state <= PK_FILL;
          end
        end
        default: begin
          state <= PK_FILL;
          occ   <= '0;
        end
      endcase
    end
  end

  // Capture accepted spikes into their lane slot.
  always_ff @(posedge engine_clk_i) begin
    if (engine_rst_i) begin
      payload <= '0;
    end else if (accept && lane_ok) begin
      payload[evt_in_lane_i] <= evt_in_spike_i;
    end
  end

  // Present the held group only in ISSUE; unoccupied lanes read as zero.
  always_comb begin
    issue_mask = (state == PK_ISSUE) ? occ : '0;
    evt_valid_o = issue_mask;
    for (int i = 0; i < int'(DP_GROUP); i++) begin
      evt_spike_o[i] = issue_mask[i] ? payload[i] : '0;
    end
  end

  assign busy_o = (|occ) | flush_pend;

`ifdef SNE_EVT_PACKER_STATS_EN
  logic [CNT_W-1:0] groups_q;
  logic [CNT_W-1:0] evts_q;

  // Free-running wrap-around counters of granted groups and accepted spikes.
  always_ff @(posedge engine_clk_i) begin
    if (engine_rst_i) begin
      groups_q <= '0;
      evts_q   <= '0;
    end else begin
      if (grant_fire) begin
        groups_q <= groups_q + CNT_W'(1);
      end
      if (accept) begin
        evts_q <= evts_q + CNT_W'(1);
      end
    end
  end

  assign stat_groups_o = groups_q;
  assign stat_evts_o   = evts_q;
`else
  assign stat_groups_o = '0;
  assign stat_evts_o   = '0;
`endif

endmodule

// File: tb/tb_evt_group_packer.sv
// Bench for evt_group_packer: vector table, directed corner sequences, random run vs a lane-set model.
// Latency: n/a.
// Backpressure: n/a.
module tb_evt_group_packer;
  import sne_evt_stream_pkg::*;

  localparam int DP = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: TIMEOUT=8
  logic          rst;
  logic          in_v;
  logic          in_rdy;
  spike_t        in_spk;
  logic [1:0]    in_lane;
  logic          flush;
  logic [3:0]    ev;
  spike_t [3:0]  es;
  logic          grant;
  logic          busy;
  logic [31:0]   sg;
  logic [31:0]   se;

  // Instance B: TIMEOUT=0
  logic          b_v;
  logic          b_rdy;
  spike_t        b_spk;
  logic [1:0]    b_lane;
  logic          b_flush;
  logic [3:0]    b_ev;
  spike_t [3:0]  b_es;
  logic          b_grant;
  logic          b_busy;
  logic [31:0]   b_sg;
  logic [31:0]   b_se;

  evt_group_packer #(.DP_GROUP(DP), .TIMEOUT(TO), .CNT_W(32)) dut (
    .engine_clk_i   (clk),
    .engine_rst_i   (rst),
    .evt_in_valid_i (in_v),
    .evt_in_ready_o (in_rdy),
    .evt_in_spike_i (in_spk),
    .evt_in_lane_i  (in_lane),
    .flush_i        (flush),
    .evt_valid_o    (ev),
    .evt_spike_o    (es),
    .spike_grant_i  (grant),
    .busy_o         (busy),
    .stat_groups_o  (sg),
    .stat_evts_o    (se)
  );

  evt_group_packer #(.DP_GROUP(DP), .TIMEOUT(0), .CNT_W(32)) dut_nt (
    .engine_clk_i   (clk),
    .engine_rst_i   (rst),
    .evt_in_valid_i (b_v),
    .evt_in_ready_o (b_rdy),
    .evt_in_spike_i (b_spk),
    .evt_in_lane_i  (b_lane),
    .flush_i        (b_flush),
    .evt_valid_o    (b_ev),
    .evt_spike_o    (b_es),
    .spike_grant_i  (b_grant),
    .busy_o         (b_busy),
    .stat_groups_o  (b_sg),
    .stat_evts_o    (b_se)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  lane;
    logic [11:0] spk;
    logic        fl;
    logic        gr;
    logic        e_rdy;
    logic [3:0]  e_val;
    logic [47:0] e_spk;
    logic        e_busy;
  } vec_t;

  vec_t tbl[11];

  // Behavioural reference: the set of lanes held, their spikes, and the cycle of the last accept.
  bit     m_held[4];
  spike_t m_spk[4];
  bit     m_iss;
  bit     m_fp;
  int     m_last_acc;
  int     m_groups;
  int     m_evts;

  initial begin
    int n;
    int acc;
    int guard;
    bit seen;
    logic [3:0]  e_val;
    logic [47:0] e_spk;
    logic        e_rdy;
    logic        e_busy;
    bit any;
    bit nany;
    bit full;
    bit accd;
    bit coll;
    bit timed;

    rst = 1'b1; in_v = 0; in_lane = 0; in_spk = '0; flush = 0; grant = 0;
    b_v = 0; b_lane = 0; b_spk = '0; b_flush = 0; b_grant = 0;
    repeat (3) next_cyc();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'(in_rdy), 64'd1);
    chk("rst_valid", 64'(ev), 64'd0);
    chk("rst_spike", 64'(es), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_stat_g", 64'(sg), 64'd0);
    chk("rst_stat_e", 64'(se), 64'd0);
    next_cyc();

    // Vector table: full group of 4, empty flush, flush with accept.
    tbl[0]  = '{1'b1, 2'd0, 12'h0A1, 1'b0, 1'b1, 1'b1, 4'h0, 48'h0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 12'h1B2, 1'b0, 1'b1, 1'b1, 4'h0, 48'h0, 1'b1};
    tbl[2]  = '{1'b1, 2'd2, 12'h2C3, 1'b0, 1'b1, 1'b1, 4'h0, 48'h0, 1'b1};
    tbl[3]  = '{1'b1, 2'd3, 12'h3D4, 1'b0, 1'b1, 1'b1, 4'h0, 48'h0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'hF, 48'h3D4_2C3_1B2_0A1, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b1, 4'h0, 48'h0, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'h0, 48'h0, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 12'h3EE, 1'b1, 1'b0, 1'b1, 4'h0, 48'h0, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h8, 48'h3EE_000_000_000, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 12'h000, 1'b0, 1'b1, 1'b0, 4'h8, 48'h3EE_000_000_000, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 12'h000, 1'b0, 1'b0, 1'b1, 4'h0, 48'h0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      in_v = tbl[i].v; in_lane = tbl[i].lane; in_spk = spike_t'(tbl[i].spk);
      flush = tbl[i].fl; grant = tbl[i].gr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 64'(in_rdy), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_valid", i), 64'(ev), 64'(tbl[i].e_val));
      chk($sformatf("tbl%0d_spike", i), 64'(es), 64'(tbl[i].e_spk));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      next_cyc();
    end
    in_v = 0; flush = 0; grant = 0;

    // Collision on lane 2, grant withheld 5 cycles.
    in_v = 1; in_lane = 2; in_spk = spike_t'(12'h2AA);
    @(negedge clk); chk("coll_first_ready", 64'(in_rdy), 64'd1);
    next_cyc();
    in_spk = spike_t'(12'h2BB); grant = 1;
    @(negedge clk); chk("coll_ready", 64'(in_rdy), 64'd0);
    chk("coll_no_beat_yet", 64'(ev), 64'd0);
    next_cyc();
    grant = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), 64'(ev), 64'h4);
      chk($sformatf("hold%0d_spike", k), 64'(es), 64'(48'h000_2AA_000_000));
      chk($sformatf("hold%0d_ready", k), 64'(in_rdy), 64'd0);
      next_cyc();
    end
    grant = 1;
    @(negedge clk); chk("hold_grant_valid", 64'(ev), 64'h4);
    next_cyc();
    grant = 0;
    @(negedge clk); chk("coll_retry_ready", 64'(in_rdy), 64'd1);
    next_cyc();
    in_v = 0;
    @(negedge clk); chk("coll_retry_busy", 64'(busy), 64'd1);
    chk("coll_retry_nobeat", 64'(ev), 64'd0);
    next_cyc();
    flush = 1;
    next_cyc();
    flush = 0;
    @(negedge clk); chk("coll_retry_valid", 64'(ev), 64'h4);
    chk("coll_retry_spike", 64'(es), 64'(48'h000_2BB_000_000));
    grant = 1; next_cyc(); grant = 0;

    // Idle timeout: beat appears 8 cycles after the accept edge.
    in_v = 1; in_lane = 1; in_spk = spike_t'(12'h1CC);
    next_cyc();
    in_v = 0;
    n = 0;
    seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      if (ev != 4'h0) seen = 1;
      else begin next_cyc(); n++; end
    end
    chk("timeout_latency", 64'(n), 64'd8);
    chk("timeout_valid", 64'(ev), 64'h2);
    grant = 1; next_cyc(); grant = 0;

    // TIMEOUT=0 never issues on its own.
    b_v = 1; b_lane = 1; b_spk = spike_t'(12'h155);
    next_cyc();
    b_v = 0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b_ev != 4'h0) seen = 1;
      next_cyc();
    end
    chk("no_timeout_beat", 64'(seen), 64'd0);
    chk("no_timeout_busy", 64'(b_busy), 64'd1);
    b_flush = 1; next_cyc(); b_flush = 0;
    @(negedge clk); chk("no_timeout_flush_valid", 64'(b_ev), 64'h2);
    b_grant = 1; next_cyc(); b_grant = 0;

    // Reset while holding a beat.
    in_v = 1; in_lane = 0; in_spk = spike_t'(12'h011); flush = 1;
    next_cyc();
    in_v = 0; flush = 0;
    @(negedge clk); chk("pre_rst_valid", 64'(ev), 64'h1);
    next_cyc();
    rst = 1;
    next_cyc();
    @(negedge clk);
    chk("midrst_valid", 64'(ev), 64'd0);
    chk("midrst_ready", 64'(in_rdy), 64'd1);
    chk("midrst_busy",  64'(busy), 64'd0);
    next_cyc();
    rst = 0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ev != 4'h0) seen = 1;
      next_cyc();
    end
    chk("post_rst_stale", 64'(seen), 64'd0);

    // 10 spikes cyclic over lanes, then flush: 3 groups, last one lanes 0,1.
    rst = 1; next_cyc(); rst = 0;
    grant = 1; acc = 0; guard = 0;
    while (acc < 10 && guard < 100) begin
      in_v = 1; in_lane = 2'(acc % 4); in_spk = spike_t'(12'($urandom));
      @(negedge clk);
      if (in_rdy) acc++;
      next_cyc();
      guard++;
    end
    in_v = 0; grant = 0;
    chk("stats_accepts", 64'(acc), 64'd10);
    flush = 1; next_cyc(); flush = 0;
    @(negedge clk); chk("stats_last_valid", 64'(ev), 64'h3);
    grant = 1; next_cyc(); grant = 0;
    @(negedge clk);
`ifdef SNE_EVT_PACKER_STATS_EN
    chk("stat_evts", 64'(se), 64'd10);
    chk("stat_groups", 64'(sg), 64'd3);
`else
    chk("stat_evts_tied", 64'(se), 64'd0);
    chk("stat_groups_tied", 64'(sg), 64'd0);
`endif

    // Random run against the lane-set model.
    rst = 1; next_cyc(); rst = 0;
    for (int i = 0; i < 4; i++) begin m_held[i] = 0; m_spk[i] = '0; end
    m_iss = 0; m_fp = 0; m_last_acc = 0; m_groups = 0; m_evts = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_v    = ((cyc % 100) < 85) ? ($urandom_range(9, 0) < 6) : 1'b0;
      in_lane = 2'($urandom_range(3, 0));
      in_spk  = spike_t'(12'($urandom));
      flush   = ($urandom_range(15, 0) == 0);
      grant   = ($urandom_range(1, 0) == 1);

      any = 0; full = 1;
      for (int l = 0; l < 4; l++) begin any |= m_held[l]; full &= m_held[l]; end
      e_rdy  = !m_iss && !m_held[in_lane];
      e_busy = any || m_fp;
      e_val  = '0; e_spk = '0;
      for (int l = 0; l < 4; l++) begin
        if (m_iss && m_held[l]) begin
          e_val[l] = 1'b1;
          e_spk[l*12 +: 12] = m_spk[l];
        end
      end

      @(negedge clk);
      chk("rnd_ready", 64'(in_rdy), 64'(e_rdy));
      chk("rnd_valid", 64'(ev), 64'(e_val));
      chk("rnd_spike", 64'(es), 64'(e_spk));
      chk("rnd_busy",  64'(busy), 64'(e_busy));

      if (m_iss) begin
        if (flush) m_fp = 1;
        if (grant) begin
          for (int l = 0; l < 4; l++) m_held[l] = 0;
          m_iss = 0;
          m_groups++;
        end
      end else begin
        accd  = in_v && !m_held[in_lane];
        coll  = in_v && m_held[in_lane];
        timed = any && !accd && ((cyc - m_last_acc) >= TO);
        if (accd) begin
          m_held[in_lane] = 1;
          m_spk[in_lane]  = in_spk;
          m_last_acc      = cyc;
          m_evts++;
        end
        nany = 0; full = 1;
        for (int l = 0; l < 4; l++) begin nany |= m_held[l]; full &= m_held[l]; end
        if (nany && (coll || full || flush || m_fp || timed)) begin
          m_iss = 1;
          m_fp  = 0;
        end
      end
      next_cyc();
    end
    in_v = 0; flush = 0; grant = 0;
    @(negedge clk);
`ifdef SNE_EVT_PACKER_STATS_EN
    chk("rnd_stat_evts", 64'(se), 64'(m_evts));
    chk("rnd_stat_groups", 64'(sg), 64'(m_groups));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
